// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-cycle imem reads and
// buffers responses in a 2-entry FIFO that decouples fetch from decode stalls.
module fetch_unit #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        redirect_valid,
    input  logic [11:0] redirect_pc,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [11:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4
);

    logic [11:0] r_pc;
    logic        r_inflight;
    logic [11:0] r_tag;
    logic [1:0]  r_cnt;
    logic [11:0] r_pc0, r_pc1;
    logic [31:0] r_inst0, r_inst1;
    logic        r_loaded;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [2:0]  w_occ;
    logic [2:0]  w_lim;

    assign w_pop   = (r_cnt != 2'd0) & if_ready;
    assign w_push  = r_inflight & ~redirect_valid;
    // count + inflight - pop < 2, rearranged to stay unsigned
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight};
    assign w_lim   = 3'd2 + {2'b00, w_pop};
    assign w_issue = ~redirect_valid & (w_occ < w_lim);

    assign imem_req  = w_issue & ~RST;
    assign imem_addr = r_pc;

    assign if_valid = (r_cnt != 2'd0);
    assign if_pc    = r_pc0;
    assign if_inst  = r_inst0;
    // Head-derived PC+4 reads as zero until the head has ever been loaded
    assign if_pc4   = r_loaded ? ({20'b0, r_pc0} + 32'd4) : 32'd0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_tag      <= 12'd0;
            r_cnt      <= 2'd0;
            r_pc0      <= 12'd0;
            r_pc1      <= 12'd0;
            r_inst0    <= 32'd0;
            r_inst1    <= 32'd0;
            r_loaded   <= 1'b0;
        end else if (redirect_valid) begin
            // Flush; entries keep their contents so the empty head holds its value
            r_cnt      <= 2'd0;
            r_inflight <= 1'b0;
            r_pc       <= {redirect_pc[11:2], 2'b00};
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc  <= r_pc + 12'd4;
                r_tag <= r_pc;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) r_loaded <= 1'b1;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_pc0   <= r_tag;
                        r_inst0 <= imem_rdata;
                    end else begin
                        r_pc1   <= r_tag;
                        r_inst1 <= imem_rdata;
                    end
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_pc0   <= r_tag;
                        r_inst0 <= imem_rdata;
                    end else begin
                        r_pc0   <= r_pc1;
                        r_inst0 <= r_inst1;
                        r_pc1   <= r_tag;
                        r_inst1 <= imem_rdata;
                    end
                end
                2'b01: begin
                    if (r_cnt == 2'd2) begin
                        r_pc0   <= r_pc1;
                        r_inst0 <= r_inst1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; imem model returns addr*16 one cycle after a request.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [11:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;

    int n_chk = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(12'h000)) dut (
        .CLK(CLK), .RST(RST),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_inst(if_inst), .if_pc4(if_pc4)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK)
        if (imem_req) imem_rdata <= {20'b0, imem_addr} << 4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive new inputs just after the falling edge, then settle before checking
    task automatic cyc(input logic rdy, input logic rv, input logic [11:0] rpc);
        @(negedge CLK);
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    // Holds reset for two cycles; returns in the first post-reset cycle
    task automatic do_reset(input logic rdy);
        @(negedge CLK);
        RST = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 12'h0;
        if_ready = rdy;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
    endtask

    initial begin
        RST = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 12'h0;
        if_ready = 1'b1;
        imem_rdata = 32'h0;
        #1;
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc",    {20'b0, if_pc},    32'd0);
        chk("rst_inst",  if_inst,           32'd0);
        chk("rst_pc4",   if_pc4,            32'd0);

        // Reset release, streaming
        do_reset(1'b1);
        chk("s0_req",  {31'b0, imem_req}, 32'd1);
        chk("s0_addr", {20'b0, imem_addr}, 32'h000);
        chk("s0_vld",  {31'b0, if_valid}, 32'd0);
        cyc(1, 0, 0);
        chk("s1_addr", {20'b0, imem_addr}, 32'h004);
        chk("s1_vld",  {31'b0, if_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            chk("s_addr", {20'b0, imem_addr}, 32'(8 + 4*i));
            chk("s_vld",  {31'b0, if_valid}, 32'd1);
            chk("s_pc",   {20'b0, if_pc}, 32'(4*i));
            chk("s_inst", if_inst, 32'(64*i));
            chk("s_pc4",  if_pc4, 32'(4*i + 4));
        end

        // Stall for 5 cycles after first valid, then release
        do_reset(1'b0);
        cyc(0, 0, 0);
        chk("st1_req", {31'b0, imem_req}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            chk("st_req", {31'b0, imem_req}, 32'd0);
            chk("st_vld", {31'b0, if_valid}, 32'd1);
            chk("st_pc",  {20'b0, if_pc}, 32'h000);
        end
        cyc(1, 0, 0);
        chk("rel_req",  {31'b0, imem_req}, 32'd1);
        chk("rel_addr", {20'b0, imem_addr}, 32'h008);
        chk("rel_pc0",  {20'b0, if_pc}, 32'h000);
        for (int i = 1; i < 4; i++) begin
            cyc(1, 0, 0);
            chk("rel_vld", {31'b0, if_valid}, 32'd1);
            chk("rel_pc",  {20'b0, if_pc}, 32'(4*i));
        end

        // Redirect with two entries buffered
        do_reset(1'b0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 12'h103);
        chk("rd_req",  {31'b0, imem_req}, 32'd0);
        cyc(0, 0, 0);
        chk("rd_req1", {31'b0, imem_req}, 32'd1);
        chk("rd_addr", {20'b0, imem_addr}, 32'h100);
        chk("rd_v1",   {31'b0, if_valid}, 32'd0);
        cyc(0, 0, 0);
        chk("rd_v2",   {31'b0, if_valid}, 32'd0);
        cyc(1, 0, 0);
        chk("rd_v3",   {31'b0, if_valid}, 32'd1);
        chk("rd_pc",   {20'b0, if_pc}, 32'h100);
        chk("rd_inst", if_inst, 32'h1000);
        cyc(1, 0, 0);
        chk("rd_pc2",  {20'b0, if_pc}, 32'h104);

        // Wrap at the top of the address space
        cyc(1, 1, 12'hFF8);
        cyc(1, 0, 0);
        chk("wr_addr", {20'b0, imem_addr}, 32'hFF8);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("wr_pc0",  {20'b0, if_pc}, 32'hFF8);
        chk("wr_p40",  if_pc4, 32'h0000_0FFC);
        cyc(1, 0, 0);
        chk("wr_pc1",  {20'b0, if_pc}, 32'hFFC);
        chk("wr_p41",  if_pc4, 32'h0000_1000);
        cyc(1, 0, 0);
        chk("wr_pc2",  {20'b0, if_pc}, 32'h000);
        chk("wr_p42",  if_pc4, 32'h0000_0004);
        chk("wr_inst", if_inst, 32'h0);

        // Back-to-back redirects: last one wins
        cyc(1, 1, 12'h040);
        cyc(1, 1, 12'h080);
        chk("bb_req0", {31'b0, imem_req}, 32'd0);
        cyc(1, 0, 0);
        chk("bb_addr", {20'b0, imem_addr}, 32'h080);
        chk("bb_v0",   {31'b0, if_valid}, 32'd0);
        cyc(1, 0, 0);
        chk("bb_v1",   {31'b0, if_valid}, 32'd0);
        cyc(1, 0, 0);
        chk("bb_pc",   {20'b0, if_pc}, 32'h080);
        chk("bb_inst", if_inst, 32'h800);
        cyc(1, 0, 0);
        chk("bb_pc2",  {20'b0, if_pc}, 32'h084);

        // Asynchronous reset between edges with two entries buffered
        do_reset(1'b0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("ar_req_pre", {31'b0, imem_req}, 32'd1);
        chk("ar_vld_pre", {31'b0, if_valid}, 32'd1);
        #1 RST = 1'b1;
        #1;
        chk("ar_req", {31'b0, imem_req}, 32'd0);
        chk("ar_vld", {31'b0, if_valid}, 32'd0);
        chk("ar_pc",  {20'b0, if_pc}, 32'h000);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("ar_addr0", {20'b0, imem_addr}, 32'h000);
        cyc(1, 0, 0);
        chk("ar_vld1", {31'b0, if_valid}, 32'd0);
        cyc(1, 0, 0);
        chk("ar_vld2", {31'b0, if_valid}, 32'd1);
        chk("ar_pc2",  {20'b0, if_pc}, 32'h000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that consumes the 12-bit next-PC chosen by the PC mux and produces the stream of (PC, instruction) pairs for decode. It owns the architectural PC register and issues reads to a single-cycle-latency instruction memory. A 2-entry buffer decouples fetch from decode stalls. It also returns the sequential PC+4 value to the PC mux.

## Interface
- RESET_PC, 12'h000, PC loaded by reset; bits [1:0] must be 0
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- redirect_valid  in  1  non-sequential PC (branch/JAL/JALR) selected this cycle
- redirect_pc  in  12  target from PC mux; bits [1:0] ignored, treated as 0
- imem_req  out  1  read request this cycle
- imem_addr  out  12  read address, valid when imem_req=1
- imem_rdata  in  32  read data, valid in the cycle after a request
- if_valid  out  1  buffer head holds a valid instruction
- if_ready  in  1  decode accepts the head this cycle
- if_pc  out  12  PC of head instruction
- if_inst  out  32  head instruction word
- if_pc4  out  32  {20'b0, if_pc} + 4, full 32-bit sum (12'hFFC gives 32'h0000_1000); routed to the mux's nextPcInc4

## Operation
- State:
  - pc: 12 bits, next fetch address.
  - inflight: 1 bit, a request was issued last cycle.
  - 2-entry FIFO of {pc, inst}, with count 0..2.
- pop = if_valid & if_ready. The head is removed at the edge.
- issue = !redirect_valid & ((count + inflight − pop) < 2).
  - imem_req = issue and imem_addr = pc, both combinational.
  - The if_ready → imem_req combinational path is permitted.
- On issue: pc ← pc + 4, modulo 4096, so 12'hFFC wraps to 12'h000. The address tag is recorded for the response.
- Response capture: when inflight=1 and redirect_valid=0, {tag, imem_rdata} is pushed at the edge.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push never finds the FIFO full; the issue rule guarantees this.
- Redirect (redirect_valid=1), at the edge:
  - FIFO is flushed (count ← 0).
  - Any response arriving this cycle is discarded.
  - pc ← {redirect_pc[11:2], 2'b00}.
  - inflight ← 0.
  - No request is issued in the redirect cycle.
  - A pop in that cycle is still reported to decode via if_ready, but it has no further effect.
- Back-to-back redirects: the last one wins, and each cycle's flush applies.
- if_valid = (count != 0). if_pc, if_inst and if_pc4 are driven from the head entry. When empty, they hold the last head contents, or zero after reset.

## Timing
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_PC, inflight = 0, count = 0, FIFO entries = 0.
  - imem_req = 0 while RST=1.
  - if_valid = 0; if_pc, if_inst, if_pc4 = 0.
- Reset asserted mid-operation discards everything, including the in-flight read.
- Latency:
  - Request in cycle N → imem_rdata sampled at the end of N+1 → if_valid visible in N+2.
  - First request occurs in the first cycle after RST deasserts.
- Redirect in cycle R: request to the target in R+1, if_valid with the target instruction in R+3.
- Steady state with if_ready=1 and no redirects: one instruction per cycle, with count oscillating at 1 and inflight=1.
- Stall: with if_ready=0, at most 2 buffered entries. Issue stops once count + inflight reaches 2. Buffered entries are not lost.
- Release after stall: the first pop cycle re-enables issue in that same cycle.

## Test plan
- Reset release with RESET_PC=0, if_ready=1, imem returning addr*16:
  - imem_addr is 0, 4, 8, … on consecutive cycles.
  - if_valid first rises 2 cycles after the first request.
  - if_pc/if_inst = 0/0, 4/64, 8/128 on consecutive cycles.
  - if_pc4 = 4, 8, 12.
- Stall: hold if_ready=0 for 5 cycles after the first if_valid.
  - imem_req drops after count + inflight = 2.
  - On release, decode sees PCs 0, 4, 8, … with no gap or duplicate.
- Redirect: assert redirect_valid with redirect_pc=12'h103 while 2 entries are buffered.
  - imem_req=0 in the redirect cycle.
  - Next request to 12'h100.
  - if_valid=0 for 2 cycles, then if_pc=12'h100.
  - The stale response is never presented.
- Wrap: redirect to 12'hFF8, if_ready=1.
  - if_pc sequence FF8, FFC, 000.
  - if_pc4 = 32'h0000_0FFC, 32'h0000_1000, 32'h0000_0004.
- Async reset mid-stream: assert RST between clock edges with 2 entries buffered.
  - if_valid and imem_req go to 0 immediately.
  - After release, fetch restarts at RESET_PC.
- Redirect in consecutive cycles to 12'h040 then 12'h080: only 12'h080 is fetched and presented.
